// File: rtl/mii_frame_scheduler.sv
// Round-robin scheduler sharing one MAC/MII frame generator between NUM_REQ requesters.
// Optional macro FRAME_SCHED_STATS_EN adds the frame and timeout statistic counters.
module mii_frame_scheduler #(
   parameter int NUM_REQ          = 4,
   parameter int PAYLOAD_MAX_SIZE = 1500,
   parameter int MIN_PAYLOAD      = 46,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic [NUM_REQ*16-1:0]  i_req_length,
   input  logic [NUM_REQ*8-1:0]   i_req_mode,
   input  logic [NUM_REQ*8-1:0]   i_req_intergap,
   input  logic                   i_tx_valid,
   output logic [NUM_REQ-1:0]     o_gnt,
   output logic [NUM_REQ-1:0]     o_done,
   output logic                   o_start,
   output logic [15:0]            o_payload_length,
   output logic [7:0]             o_mode,
   output logic [7:0]             o_intergap,
   output logic                   o_busy,
   output logic                   o_timeout,
   output logic [31:0]            o_frame_count,
   output logic [15:0]            o_timeout_count
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_TX, S_BUSY, S_GAP} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      r_winner;
   logic [IW-1:0]      w_winIdx;
   logic               w_anyReq;
   logic [15:0]        w_rawLen;
   logic [15:0]        w_clampLen;
   logic [15:0]        r_len;
   logic [7:0]         r_mode;
   logic [7:0]         r_gap;
   logic [7:0]         w_gapTarget;
   logic [7:0]         r_gapCnt;
   logic [31:0]        r_toCnt;
   logic [NUM_REQ-1:0] r_done;
   logic               r_timeout;
   logic               w_grant;
   logic               w_frameDone;
   logic               w_timeoutFire;

   // Search starts at r_ptr; scanning offsets downward leaves the nearest requester as winner.
   always_comb begin
      w_winIdx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[(int'(r_ptr) + i) % NUM_REQ]) begin
            w_winIdx = IW'((int'(r_ptr) + i) % NUM_REQ);
         end
      end
   end

   assign w_anyReq = |i_req;
   assign w_rawLen = i_req_length[int'(w_winIdx)*16 +: 16];

   always_comb begin
      if (w_rawLen < 16'(MIN_PAYLOAD)) begin
         w_clampLen = 16'(MIN_PAYLOAD);
      end else if (w_rawLen > 16'(PAYLOAD_MAX_SIZE)) begin
         w_clampLen = 16'(PAYLOAD_MAX_SIZE);
      end else begin
         w_clampLen = w_rawLen;
      end
   end

   // A zero gap still spends one cycle in GAP so IDLE is never re-entered back to back.
   assign w_gapTarget = (r_gap == 8'd0) ? 8'd1 : r_gap;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      o_start = 1'b0;
      o_gnt   = '0;
      case (r_state)
         S_IDLE: begin
            if (i_enable && w_anyReq) begin
               w_next = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            o_start = 1'b1;
            o_gnt   = NUM_REQ'(1) << r_winner;
            w_next  = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (i_tx_valid) begin
               w_next = S_BUSY;
            end else if (r_toCnt == 32'(TIMEOUT_CYCLES - 1)) begin
               w_next = S_GAP;
            end
         end
         S_BUSY: begin
            if (!i_tx_valid) begin
               w_next = S_GAP;
            end
         end
         S_GAP: begin
            if (r_gapCnt == w_gapTarget - 8'd1) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_grant       = (r_state == S_IDLE) && (w_next == S_LAUNCH);
   assign w_frameDone   = (r_state == S_BUSY) && !i_tx_valid;
   assign w_timeoutFire = (r_state == S_WAIT_TX) && !i_tx_valid &&
                          (r_toCnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_ptr     <= '0;
         r_winner  <= '0;
         r_len     <= '0;
         r_mode    <= '0;
         r_gap     <= '0;
         r_toCnt   <= '0;
         r_gapCnt  <= '0;
         r_done    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_done    <= '0;
         r_timeout <= 1'b0;
         if (w_grant) begin
            r_winner <= w_winIdx;
            r_ptr    <= (w_winIdx == IW'(NUM_REQ - 1)) ? '0 : w_winIdx + 1'b1;
            r_len    <= w_clampLen;
            r_mode   <= i_req_mode[int'(w_winIdx)*8 +: 8];
            r_gap    <= i_req_intergap[int'(w_winIdx)*8 +: 8];
         end
         if (r_state == S_LAUNCH) begin
            r_toCnt <= '0;
         end else if (r_state == S_WAIT_TX) begin
            r_toCnt <= r_toCnt + 32'd1;
         end
         if (r_state == S_GAP) begin
            r_gapCnt <= r_gapCnt + 8'd1;
         end else begin
            r_gapCnt <= '0;
         end
         if (w_frameDone) begin
            r_done <= NUM_REQ'(1) << r_winner;
         end
         if (w_timeoutFire) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_done           = r_done;
   assign o_timeout        = r_timeout;
   assign o_payload_length = r_len;
   assign o_mode           = r_mode;
   assign o_intergap       = r_gap;
   assign o_busy           = (r_state != S_IDLE);

`ifdef FRAME_SCHED_STATS_EN
   logic [31:0] r_frameCount;
   logic [15:0] r_timeoutCount;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_frameCount   <= '0;
         r_timeoutCount <= '0;
      end else begin
         if (w_frameDone) begin
            r_frameCount <= r_frameCount + 32'd1;
         end
         if (w_timeoutFire) begin
            r_timeoutCount <= r_timeoutCount + 16'd1;
         end
      end
   end

   assign o_frame_count   = r_frameCount;
   assign o_timeout_count = r_timeoutCount;
`else
   assign o_frame_count   = '0;
   assign o_timeout_count = '0;
`endif

endmodule

// File: tb/tb_mii_frame_scheduler.sv
// Self-checking bench for mii_frame_scheduler: a transaction-level model compared every cycle
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_mii_frame_scheduler;
   localparam int N   = 4;
   localparam int TMO = 16;
`ifdef FRAME_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_enable = 1'b1;
   logic [N-1:0]  i_req = '0;
   logic [N*16-1:0] i_req_length = '0;
   logic [N*8-1:0]  i_req_mode = '0;
   logic [N*8-1:0]  i_req_intergap = '0;
   logic          i_tx_valid = 1'b0;
   logic [N-1:0]  o_gnt;
   logic [N-1:0]  o_done;
   logic          o_start;
   logic [15:0]   o_payload_length;
   logic [7:0]    o_mode;
   logic [7:0]    o_intergap;
   logic          o_busy;
   logic          o_timeout;
   logic [31:0]   o_frame_count;
   logic [15:0]   o_timeout_count;

   int nChecks = 0;
   int nErrors = 0;

   mii_frame_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_req(i_req),
      .i_req_length(i_req_length), .i_req_mode(i_req_mode), .i_req_intergap(i_req_intergap),
      .i_tx_valid(i_tx_valid), .o_gnt(o_gnt), .o_done(o_done), .o_start(o_start),
      .o_payload_length(o_payload_length), .o_mode(o_mode), .o_intergap(o_intergap),
      .o_busy(o_busy), .o_timeout(o_timeout), .o_frame_count(o_frame_count),
      .o_timeout_count(o_timeout_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model phases: 0 idle, 1 launch, 2 waiting for txValid, 3 transmitting, 4 gap.
   int mStage = 0, mPtr = 0, mWinner = 0, mWait = 0, mGapLeft = 0;
   bit mValid = 1'b0;
   logic [15:0] eLen = '0;
   logic [7:0]  eMode = '0, eGap = '0;
   logic [N-1:0] eGnt = '0, eDone = '0;
   logic eStart = 1'b0, eTimeout = 1'b0;
   logic [31:0] eFrames = '0;
   logic [15:0] eTimeouts = '0;

   function automatic logic [15:0] clampLen(input logic [15:0] l);
      if (l < 16'd46) return 16'd46;
      if (l > 16'd1500) return 16'd1500;
      return l;
   endfunction

   always @(posedge clk) begin
      eStart = 1'b0; eGnt = '0; eDone = '0; eTimeout = 1'b0;
      if (i_rst) begin
         mValid = 1'b1; mStage = 0; mPtr = 0; mWinner = 0; mWait = 0; mGapLeft = 0;
         eLen = '0; eMode = '0; eGap = '0; eFrames = '0; eTimeouts = '0;
      end else if (mValid) begin
         case (mStage)
            0: if (i_enable && i_req != '0) begin
                  mWinner = -1;
                  for (int off = 0; off < N && mWinner < 0; off++)
                     if (i_req[(mPtr + off) % N]) mWinner = (mPtr + off) % N;
                  mPtr  = (mWinner + 1) % N;
                  eLen  = clampLen(i_req_length[mWinner*16 +: 16]);
                  eMode = i_req_mode[mWinner*8 +: 8];
                  eGap  = i_req_intergap[mWinner*8 +: 8];
                  eStart = 1'b1;
                  eGnt = N'(1 << mWinner);
                  mStage = 1;
               end
            1: begin mStage = 2; mWait = 0; end
            2: if (i_tx_valid) mStage = 3;
               else begin
                  mWait++;
                  if (mWait == TMO) begin
                     eTimeout = 1'b1; eTimeouts++; mStage = 4;
                     mGapLeft = (eGap == 0) ? 1 : int'(eGap);
                  end
               end
            3: if (!i_tx_valid) begin
                  eDone = N'(1 << mWinner); eFrames++; mStage = 4;
                  mGapLeft = (eGap == 0) ? 1 : int'(eGap);
               end
            default: begin
               mGapLeft--;
               if (mGapLeft == 0) mStage = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("gnt", 32'(o_gnt), 32'(eGnt));
         checkOutput("start", 32'(o_start), 32'(eStart));
         checkOutput("done", 32'(o_done), 32'(eDone));
         checkOutput("timeout", 32'(o_timeout), 32'(eTimeout));
         checkOutput("busy", 32'(o_busy), 32'(mStage != 0));
         checkOutput("length", 32'(o_payload_length), 32'(eLen));
         checkOutput("mode", 32'(o_mode), 32'(eMode));
         checkOutput("intergap", 32'(o_intergap), 32'(eGap));
         checkOutput("frameCount", o_frame_count, STATS ? eFrames : 32'd0);
         checkOutput("timeoutCount", 32'(o_timeout_count), STATS ? 32'(eTimeouts) : 32'd0);
      end
   end

   task automatic applyStimulus(input logic en, input logic [N-1:0] req);
      @(negedge clk); #1;
      i_enable = en;
      i_req = req;
   endtask

   task automatic setDesc(input int k, input logic [15:0] len, input logic [7:0] mode, input logic [7:0] gap);
      i_req_length[k*16 +: 16] = len;
      i_req_mode[k*8 +: 8] = mode;
      i_req_intergap[k*8 +: 8] = gap;
   endtask

   task automatic applyReset();
      @(negedge clk); #1;
      i_rst = 1'b1; i_req = '0; i_tx_valid = 1'b0;
      @(negedge clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic waitStart(output int idx);
      idx = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (o_start) begin
            idx = 9;
            for (int i = 0; i < N; i++) if (o_gnt[i]) idx = i;
            return;
         end
      end
      nChecks++; nErrors++;
      $display("[TB] FAIL waitStart actual=none required=o_start");
   endtask

   task automatic waitDone(output logic [N-1:0] d);
      d = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (o_done != '0) begin d = o_done; return; end
      end
      nChecks++; nErrors++;
      $display("[TB] FAIL waitDone actual=none required=o_done");
   endtask

   task automatic waitIdle();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!o_busy) return;
      end
      nChecks++; nErrors++;
      $display("[TB] FAIL waitIdle actual=busy required=idle");
   endtask

   // Called at the LAUNCH negedge: update requests, then emulate a generator txValid burst.
   task automatic runFrame(input int txCycles, input logic [N-1:0] reqAfter);
      #1 i_req = reqAfter;
      @(negedge clk); #1 i_tx_valid = 1'b1;
      repeat (txCycles) @(negedge clk);
      #1 i_tx_valid = 1'b0;
   endtask

   initial begin
      int idx;
      int cnt;
      logic [N-1:0] d;
      int expOrder[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

      repeat (3) @(negedge clk);
      #1 i_rst = 1'b0;
      @(negedge clk);
      checkOutput("resetBusy", 32'(o_busy), 32'd0);
      checkOutput("resetLength", 32'(o_payload_length), 32'd0);
      checkOutput("resetGnt", 32'(o_gnt), 32'd0);

      $display("[TB] single frame, gap 12");
      setDesc(0, 16'd64, 8'd1, 8'd12);
      applyStimulus(1'b1, 4'b0001);
      waitStart(idx);
      checkOutput("t1Winner", idx, 0);
      checkOutput("t1Length", 32'(o_payload_length), 32'd64);
      checkOutput("t1Mode", 32'(o_mode), 32'd1);
      checkOutput("t1Gap", 32'(o_intergap), 32'd12);
      runFrame(10, 4'b0000);
      waitDone(d);
      checkOutput("t1Done", 32'(d), 32'd1);
      #1 i_req = 4'b0001;
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         cnt++;
         if (o_start) break;
      end
      checkOutput("t1DoneToStart", cnt, 13);
      runFrame(4, 4'b0000);
      waitIdle();

      $display("[TB] round robin over 8 frames");
      applyReset();
      for (int k = 0; k < N; k++) setDesc(k, 16'(100 * (k + 1)), 8'(k + 2), 8'd2);
      applyStimulus(1'b1, 4'b1111);
      for (int f = 0; f < 8; f++) begin
         waitStart(idx);
         checkOutput("rrOrder", idx, expOrder[f]);
         runFrame(3, 4'b1111);
      end
      #1 i_req = '0;
      waitIdle();

      $display("[TB] length clamp");
      setDesc(0, 16'd10, 8'd5, 8'd1);
      setDesc(1, 16'd2000, 8'd6, 8'd1);
      setDesc(2, 16'd46, 8'd7, 8'd0);
      applyStimulus(1'b1, 4'b0001);
      waitStart(idx);
      checkOutput("clampLowWinner", idx, 0);
      runFrame(3, 4'b0000);
      checkOutput("clampLow", 32'(o_payload_length), 32'd46);
      waitIdle();
      applyStimulus(1'b1, 4'b0010);
      waitStart(idx);
      checkOutput("clampHighWinner", idx, 1);
      runFrame(3, 4'b0000);
      checkOutput("clampHigh", 32'(o_payload_length), 32'd1500);
      waitIdle();
      applyStimulus(1'b1, 4'b0100);
      waitStart(idx);
      runFrame(3, 4'b0000);
      checkOutput("clampEdge", 32'(o_payload_length), 32'd46);
      waitIdle();

      $display("[TB] txValid never asserted");
      setDesc(0, 16'd80, 8'd2, 8'd3);
      applyStimulus(1'b1, 4'b0001);
      waitStart(idx);
      checkOutput("toWinner", idx, 0);
      #1 i_req = '0;
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         cnt++;
         if (o_timeout) break;
      end
      checkOutput("toLatency", cnt, 17);
      checkOutput("toCount", 32'(o_timeout_count), STATS ? 32'd1 : 32'd0);
      waitIdle();

      $display("[TB] reset during BUSY");
      setDesc(1, 16'd300, 8'd9, 8'd4);
      applyStimulus(1'b1, 4'b0010);
      waitStart(idx);
      checkOutput("rstWinner", idx, 1);
      #1 i_req = '0;
      @(negedge clk); #1 i_tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1 i_rst = 1'b1; i_tx_valid = 1'b0;
      @(negedge clk);
      checkOutput("rstBusy", 32'(o_busy), 32'd0);
      checkOutput("rstStart", 32'(o_start), 32'd0);
      checkOutput("rstGnt", 32'(o_gnt), 32'd0);
      checkOutput("rstDone", 32'(o_done), 32'd0);
      checkOutput("rstLength", 32'(o_payload_length), 32'd0);
      checkOutput("rstMode", 32'(o_mode), 32'd0);
      checkOutput("rstGap", 32'(o_intergap), 32'd0);
      checkOutput("rstTimeout", 32'(o_timeout), 32'd0);
      checkOutput("rstFrames", o_frame_count, 32'd0);
      checkOutput("rstTimeouts", 32'(o_timeout_count), 32'd0);
      #1 i_rst = 1'b0; i_req = 4'b0011;
      waitStart(idx);
      checkOutput("rstFirstWinner", idx, 0);
      runFrame(3, 4'b0000);
      waitIdle();

      $display("[TB] enable dropped during BUSY");
      setDesc(0, 16'd64, 8'd1, 8'd4);
      applyStimulus(1'b1, 4'b0001);
      waitStart(idx);
      checkOutput("enWinner", idx, 0);
      #1 i_req = 4'b0010;
      @(negedge clk); #1 i_tx_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1 i_enable = 1'b0;
      repeat (2) @(negedge clk);
      #1 i_tx_valid = 1'b0;
      waitDone(d);
      checkOutput("enDone", 32'(d), 32'd1);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_gnt != '0) cnt++;
      end
      checkOutput("enNoGrant", cnt, 0);
      checkOutput("enIdle", 32'(o_busy), 32'd0);
      #1 i_enable = 1'b1;
      waitStart(idx);
      checkOutput("enResumeWinner", idx, 1);
      runFrame(3, 4'b0000);
      waitIdle();

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule
